// File: rtl/axi_pkg.sv
// Shared AXI write-path constants, response codes and the write-router state encoding.
package axi_pkg;

    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlvErr = 2'b10;
    localparam logic [1:0] RespDecErr = 2'b11;

    localparam logic [2:0] AwSizeDefault  = 3'd2;
    localparam logic [1:0] AwBurstDefault = 2'b01;

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StData,
        StResp,
        StErrData,
        StErrResp
    } wr_state_t;

    // A single-slave build still needs a 1-bit select to index with.
    function automatic int unsigned sel_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axi_wr_addr_decode.sv
// Maps the 64 KiB page (ADDR[31:16]) to a slave index; hit is low for unmapped pages.
module axi_wr_addr_decode
    import axi_pkg::*;
#(
    parameter int unsigned NUM_SLAVES = 2,
    parameter int unsigned SEL_BITS   = sel_width(NUM_SLAVES)
) (
    input  logic [15:0]         page_i,
    output logic [SEL_BITS-1:0] sel_o,
    output logic                hit_o
);

    assign hit_o = page_i < 16'(NUM_SLAVES);
    assign sel_o = page_i[SEL_BITS-1:0];

endmodule

// File: rtl/axi_wr_router.sv
// Single-outstanding AXI write router: one master to NUM_SLAVES slaves, DECERR for unmapped pages.
// Optional WR_BEAT_CHECK_EN adds a beat counter, the sticky wr_err output and SLVERR override.
module axi_wr_router
    import axi_pkg::*;
#(
    parameter int unsigned NUM_SLAVES = 2,
    parameter int unsigned ID_BITS    = 4,
    parameter int unsigned IDS_BITS   = 8,
    parameter int unsigned ADDR_BITS  = 32,
    parameter int unsigned DATA_BITS  = 32
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [ID_BITS-1:0]                    m_awid,
    input  logic [ADDR_BITS-1:0]                  m_awaddr,
    input  logic [3:0]                            m_awlen,
    input  logic [2:0]                            m_awsize,
    input  logic [1:0]                            m_awburst,
    input  logic                                  m_awvalid,
    output logic                                  m_awready,
    input  logic [DATA_BITS-1:0]                  m_wdata,
    input  logic [DATA_BITS/8-1:0]                m_wstrb,
    input  logic                                  m_wlast,
    input  logic                                  m_wvalid,
    output logic                                  m_wready,
    input  logic                                  m_bready,
    output logic [ID_BITS-1:0]                    m_bid,
    output logic [1:0]                            m_bresp,
    output logic                                  m_bvalid,
    output logic [NUM_SLAVES-1:0][IDS_BITS-1:0]   s_awid,
    output logic [NUM_SLAVES-1:0][ADDR_BITS-1:0]  s_awaddr,
    output logic [NUM_SLAVES-1:0][3:0]            s_awlen,
    output logic [NUM_SLAVES-1:0][2:0]            s_awsize,
    output logic [NUM_SLAVES-1:0][1:0]            s_awburst,
    output logic [NUM_SLAVES-1:0]                 s_awvalid,
    input  logic [NUM_SLAVES-1:0]                 s_awready,
    output logic [NUM_SLAVES-1:0][DATA_BITS-1:0]  s_wdata,
    output logic [NUM_SLAVES-1:0][DATA_BITS/8-1:0] s_wstrb,
    output logic [NUM_SLAVES-1:0]                 s_wlast,
    output logic [NUM_SLAVES-1:0]                 s_wvalid,
    input  logic [NUM_SLAVES-1:0]                 s_wready,
    input  logic [NUM_SLAVES-1:0][IDS_BITS-1:0]   s_bid,
    input  logic [NUM_SLAVES-1:0][1:0]            s_bresp,
    input  logic [NUM_SLAVES-1:0]                 s_bvalid,
    output logic [NUM_SLAVES-1:0]                 s_bready,
`ifdef WR_BEAT_CHECK_EN
    output logic                                  wr_err,
`endif
    output logic                                  wr_busy
);

    localparam int unsigned SelBits = sel_width(NUM_SLAVES);

    wr_state_t              state_q, state_d;
    logic [ID_BITS-1:0]     id_q, id_d;
    logic [ADDR_BITS-1:0]   addr_q, addr_d;
    logic [3:0]             len_q, len_d;
    logic [2:0]             size_q, size_d;
    logic [1:0]             burst_q, burst_d;
    logic [SelBits-1:0]     sel_q, sel_d;
    logic [SelBits-1:0]     dec_sel;
    logic                   dec_hit;

    // Upper slave ID bits carry only the zero pad and are dropped on the way back.
    logic                   unused_bid;
    assign unused_bid = ^s_bid;

`ifdef WR_BEAT_CHECK_EN
    logic [3:0] beat_q, beat_d;
    logic       err_q, err_d;
    assign wr_err = err_q;
`endif

    axi_wr_addr_decode #(
        .NUM_SLAVES (NUM_SLAVES),
        .SEL_BITS   (SelBits)
    ) u_decode (
        .page_i (m_awaddr[31:16]),
        .sel_o  (dec_sel),
        .hit_o  (dec_hit)
    );

    assign wr_busy = (state_q != StIdle);

    always_comb begin
        state_d   = state_q;
        id_d      = id_q;
        addr_d    = addr_q;
        len_d     = len_q;
        size_d    = size_q;
        burst_d   = burst_q;
        sel_d     = sel_q;
`ifdef WR_BEAT_CHECK_EN
        beat_d    = beat_q;
        err_d     = err_q;
`endif
        m_awready = 1'b0;
        m_wready  = 1'b0;
        m_bvalid  = 1'b0;
        m_bresp   = RespOkay;
        m_bid     = '0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            s_awid[k]    = '0;
            s_awaddr[k]  = '0;
            s_awlen[k]   = '0;
            s_awsize[k]  = AwSizeDefault;
            s_awburst[k] = AwBurstDefault;
            s_awvalid[k] = 1'b0;
            s_wdata[k]   = '0;
            s_wstrb[k]   = '1;
            s_wlast[k]   = 1'b0;
            s_wvalid[k]  = 1'b0;
            s_bready[k]  = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                m_awready = 1'b1;
                if (m_awvalid) begin
                    id_d    = m_awid;
                    addr_d  = m_awaddr;
                    len_d   = m_awlen;
                    size_d  = m_awsize;
                    burst_d = m_awburst;
                    sel_d   = dec_sel;
                    state_d = dec_hit ? StAddr : StErrData;
`ifdef WR_BEAT_CHECK_EN
                    err_d   = 1'b0;
                    beat_d  = '0;
`endif
                end
            end
            StAddr: begin
                for (int k = 0; k < NUM_SLAVES; k++) begin
                    if (sel_q == SelBits'(k)) begin
                        s_awid[k]    = IDS_BITS'(id_q);
                        s_awaddr[k]  = addr_q;
                        s_awlen[k]   = len_q;
                        s_awsize[k]  = size_q;
                        s_awburst[k] = burst_q;
                        s_awvalid[k] = 1'b1;
                        if (s_awready[k]) begin
                            state_d = StData;
                        end
                    end
                end
`ifdef WR_BEAT_CHECK_EN
                beat_d = '0;
`endif
            end
            StData: begin
                for (int k = 0; k < NUM_SLAVES; k++) begin
                    if (sel_q == SelBits'(k)) begin
                        s_wdata[k]  = m_wdata;
                        s_wstrb[k]  = m_wstrb;
                        s_wlast[k]  = m_wlast;
                        s_wvalid[k] = m_wvalid;
                        m_wready    = s_wready[k];
                    end
                end
                if (m_wvalid && m_wready && m_wlast) begin
                    state_d = StResp;
                end
            end
            StResp: begin
                for (int k = 0; k < NUM_SLAVES; k++) begin
                    if (sel_q == SelBits'(k)) begin
                        m_bvalid    = s_bvalid[k];
                        m_bresp     = s_bresp[k];
                        m_bid       = s_bid[k][ID_BITS-1:0];
                        s_bready[k] = m_bready;
`ifdef WR_BEAT_CHECK_EN
                        if (err_q && (s_bresp[k] == RespOkay)) begin
                            m_bresp = RespSlvErr;
                        end
`endif
                    end
                end
                if (m_bvalid && m_bready) begin
                    state_d = StIdle;
                end
            end
            StErrData: begin
                m_wready = 1'b1;
                if (m_wvalid && m_wlast) begin
                    state_d = StErrResp;
                end
            end
            StErrResp: begin
                m_bvalid = 1'b1;
                m_bresp  = RespDecErr;
                m_bid    = id_q;
                if (m_bready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

`ifdef WR_BEAT_CHECK_EN
        // Early WLAST or a missing WLAST on the final beat both flag a length violation.
        if (((state_q == StData) || (state_q == StErrData)) && m_wvalid && m_wready) begin
            if (m_wlast != (beat_q == len_q)) begin
                err_d = 1'b1;
            end
            beat_d = beat_q + 4'd1;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            id_q    <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            size_q  <= '0;
            burst_q <= '0;
            sel_q   <= '0;
`ifdef WR_BEAT_CHECK_EN
            beat_q  <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            size_q  <= size_d;
            burst_q <= burst_d;
            sel_q   <= sel_d;
`ifdef WR_BEAT_CHECK_EN
            beat_q  <= beat_d;
            err_q   <= err_d;
`endif
        end
    end

endmodule

// File: tb/tb_axi_wr_router.sv
// Directed self-checking bench for axi_wr_router with four slaves.
module tb_axi_wr_router;

    localparam int NS = 4;
    localparam int IDB = 4;
    localparam int IDSB = 8;
    localparam int AB = 32;
    localparam int DB = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [IDB-1:0]            m_awid;
    logic [AB-1:0]             m_awaddr;
    logic [3:0]                m_awlen;
    logic [2:0]                m_awsize;
    logic [1:0]                m_awburst;
    logic                      m_awvalid, m_awready;
    logic [DB-1:0]             m_wdata;
    logic [DB/8-1:0]           m_wstrb;
    logic                      m_wlast, m_wvalid, m_wready;
    logic                      m_bready, m_bvalid;
    logic [IDB-1:0]            m_bid;
    logic [1:0]                m_bresp;
    logic [NS-1:0][IDSB-1:0]   s_awid;
    logic [NS-1:0][AB-1:0]     s_awaddr;
    logic [NS-1:0][3:0]        s_awlen;
    logic [NS-1:0][2:0]        s_awsize;
    logic [NS-1:0][1:0]        s_awburst;
    logic [NS-1:0]             s_awvalid, s_awready;
    logic [NS-1:0][DB-1:0]     s_wdata;
    logic [NS-1:0][DB/8-1:0]   s_wstrb;
    logic [NS-1:0]             s_wlast, s_wvalid, s_wready;
    logic [NS-1:0][IDSB-1:0]   s_bid;
    logic [NS-1:0][1:0]        s_bresp;
    logic [NS-1:0]             s_bvalid, s_bready;
    logic                      wr_busy;
`ifdef WR_BEAT_CHECK_EN
    logic                      wr_err;
`endif

    int n_cmp = 0;
    int n_fail = 0;

    axi_wr_router #(
        .NUM_SLAVES (NS),
        .ID_BITS    (IDB),
        .IDS_BITS   (IDSB),
        .ADDR_BITS  (AB),
        .DATA_BITS  (DB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .m_awid    (m_awid),
        .m_awaddr  (m_awaddr),
        .m_awlen   (m_awlen),
        .m_awsize  (m_awsize),
        .m_awburst (m_awburst),
        .m_awvalid (m_awvalid),
        .m_awready (m_awready),
        .m_wdata   (m_wdata),
        .m_wstrb   (m_wstrb),
        .m_wlast   (m_wlast),
        .m_wvalid  (m_wvalid),
        .m_wready  (m_wready),
        .m_bready  (m_bready),
        .m_bid     (m_bid),
        .m_bresp   (m_bresp),
        .m_bvalid  (m_bvalid),
        .s_awid    (s_awid),
        .s_awaddr  (s_awaddr),
        .s_awlen   (s_awlen),
        .s_awsize  (s_awsize),
        .s_awburst (s_awburst),
        .s_awvalid (s_awvalid),
        .s_awready (s_awready),
        .s_wdata   (s_wdata),
        .s_wstrb   (s_wstrb),
        .s_wlast   (s_wlast),
        .s_wvalid  (s_wvalid),
        .s_wready  (s_wready),
        .s_bid     (s_bid),
        .s_bresp   (s_bresp),
        .s_bvalid  (s_bvalid),
        .s_bready  (s_bready),
`ifdef WR_BEAT_CHECK_EN
        .wr_err    (wr_err),
`endif
        .wr_busy   (wr_busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        m_awid = '0; m_awaddr = '0; m_awlen = '0; m_awsize = 3'd2; m_awburst = 2'b01;
        m_awvalid = 1'b0; m_wdata = '0; m_wstrb = '1; m_wlast = 1'b0; m_wvalid = 1'b0;
        m_bready = 1'b0; s_awready = '0; s_wready = '0; s_bid = '0; s_bresp = '0; s_bvalid = '0;
    endtask

    task automatic aw_send(input logic [31:0] a, input logic [3:0] id, input logic [3:0] len);
        m_awvalid = 1'b1; m_awaddr = a; m_awid = id; m_awlen = len;
        tick();
        m_awvalid = 1'b0; m_awaddr = '0; m_awid = '0; m_awlen = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        #1 rst = 1'b0;
        #2;
        n_cmp++; if (wr_busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got=%b exp=0", wr_busy); end
        n_cmp++; if (m_awready !== 1'b1) begin n_fail++; $display("FAIL rst_awready got=%b exp=1", m_awready); end
        n_cmp++; if ({s_awvalid, s_wvalid, s_bready, m_bvalid, m_wready} !== 13'b0) begin
            n_fail++; $display("FAIL rst_valids got=%b exp=0", {s_awvalid, s_wvalid, s_bready, m_bvalid, m_wready}); end
        n_cmp++; if (s_awsize !== 12'b010_010_010_010) begin n_fail++; $display("FAIL rst_awsize got=%h exp=492", s_awsize); end
        n_cmp++; if (s_awburst !== 8'b0101_0101) begin n_fail++; $display("FAIL rst_awburst got=%b exp=01010101", s_awburst); end
        n_cmp++; if (s_wstrb !== 16'hFFFF) begin n_fail++; $display("FAIL rst_wstrb got=%h exp=ffff", s_wstrb); end
        n_cmp++; if ({s_awaddr, s_wdata, s_wlast} !== '0) begin n_fail++; $display("FAIL rst_data got=nonzero exp=0"); end
        @(posedge clk);
        #1 rst = 1'b1;
        tick();
    endtask

    task automatic test_single();
        aw_send(32'h0000_0100, 4'h3, 4'd0);
        n_cmp++; if (s_awvalid !== 4'b0001) begin n_fail++; $display("FAIL t1_awvalid got=%b exp=0001", s_awvalid); end
        n_cmp++; if (s_awaddr[0] !== 32'h0000_0100) begin n_fail++; $display("FAIL t1_awaddr got=%h exp=00000100", s_awaddr[0]); end
        n_cmp++; if (s_awid[0] !== 8'h03) begin n_fail++; $display("FAIL t1_awid got=%h exp=03", s_awid[0]); end
        n_cmp++; if (m_awready !== 1'b0 || wr_busy !== 1'b1) begin
            n_fail++; $display("FAIL t1_busy got=%b%b exp=01", m_awready, wr_busy); end
        s_awready = '1;
        tick();
        s_awready = '0;
        m_wvalid = 1'b1; m_wdata = 32'hDEAD_BEEF; m_wlast = 1'b1; s_wready = '1;
        #1;
        n_cmp++; if (s_awvalid !== 4'b0000) begin n_fail++; $display("FAIL t1_aw_drop got=%b exp=0000", s_awvalid); end
        n_cmp++; if (s_wvalid !== 4'b0001) begin n_fail++; $display("FAIL t1_wvalid got=%b exp=0001", s_wvalid); end
        n_cmp++; if (s_wdata[0] !== 32'hDEAD_BEEF || s_wlast[0] !== 1'b1) begin
            n_fail++; $display("FAIL t1_wdata got=%h/%b exp=deadbeef/1", s_wdata[0], s_wlast[0]); end
        n_cmp++; if (s_wdata[1] !== 32'h0 || m_wready !== 1'b1) begin
            n_fail++; $display("FAIL t1_wother got=%h/%b exp=0/1", s_wdata[1], m_wready); end
        tick();
        m_wvalid = 1'b0; m_wlast = 1'b0;
        s_bvalid = 4'b0001; s_bid[0] = 8'h03; s_bresp[0] = 2'b00; m_bready = 1'b1;
        #1;
        n_cmp++; if (m_bvalid !== 1'b1 || m_bresp !== 2'b00 || m_bid !== 4'h3) begin
            n_fail++; $display("FAIL t1_b got=%b/%b/%h exp=1/00/3", m_bvalid, m_bresp, m_bid); end
        n_cmp++; if (s_bready !== 4'b0001) begin n_fail++; $display("FAIL t1_bready got=%b exp=0001", s_bready); end
        tick();
        idle_inputs();
        n_cmp++; if (wr_busy !== 1'b0) begin n_fail++; $display("FAIL t1_done got=%b exp=0", wr_busy); end
    endtask

    task automatic test_burst();
        aw_send(32'h0003_0040, 4'hA, 4'd3);
        n_cmp++; if (s_awvalid !== 4'b1000) begin n_fail++; $display("FAIL t2_awvalid got=%b exp=1000", s_awvalid); end
        n_cmp++; if (s_awid[3] !== 8'h0A || s_awlen[3] !== 4'd3) begin
            n_fail++; $display("FAIL t2_awid got=%h/%h exp=0a/3", s_awid[3], s_awlen[3]); end
        s_awready = '1;
        tick();
        s_awready = '0;
        for (int i = 0; i < 4; i++) begin
            m_wvalid = 1'b1; m_wdata = 32'h1000_0000 + i; m_wlast = (i == 3); s_wready = '1;
            #1;
            n_cmp++; if (s_wvalid !== 4'b1000 || s_wdata[3] !== 32'h1000_0000 + i) begin
                n_fail++; $display("FAIL t2_beat%0d got=%b/%h exp=1000/%h", i, s_wvalid, s_wdata[3], 32'h1000_0000 + i); end
            tick();
        end
        m_wvalid = 1'b0; m_wlast = 1'b0;
        s_bvalid = 4'b1000; s_bid[3] = 8'h5A; s_bresp[3] = 2'b00; m_bready = 1'b1;
        #1;
        n_cmp++; if (m_bvalid !== 1'b1 || m_bid !== 4'hA || s_bready !== 4'b1000) begin
            n_fail++; $display("FAIL t2_b got=%b/%h/%b exp=1/a/1000", m_bvalid, m_bid, s_bready); end
        tick();
        idle_inputs();
    endtask

    task automatic test_unmapped();
        aw_send(32'h0007_0000, 4'h5, 4'd1);
        n_cmp++; if (s_awvalid !== 4'b0000 || wr_busy !== 1'b1) begin
            n_fail++; $display("FAIL t3_aw got=%b/%b exp=0000/1", s_awvalid, wr_busy); end
        for (int i = 0; i < 2; i++) begin
            m_wvalid = 1'b1; m_wlast = (i == 1); s_wready = '1;
            #1;
            n_cmp++; if (m_wready !== 1'b1 || s_wvalid !== 4'b0000) begin
                n_fail++; $display("FAIL t3_sink%0d got=%b/%b exp=1/0000", i, m_wready, s_wvalid); end
            tick();
        end
        m_wvalid = 1'b0; m_wlast = 1'b0;
        #1;
        n_cmp++; if (m_bvalid !== 1'b1 || m_bresp !== 2'b11 || m_bid !== 4'h5 || s_awvalid !== 4'b0) begin
            n_fail++; $display("FAIL t3_decerr got=%b/%b/%h/%b exp=1/11/5/0000", m_bvalid, m_bresp, m_bid, s_awvalid); end
        m_bready = 1'b1;
        tick();
        idle_inputs();
        n_cmp++; if (wr_busy !== 1'b0) begin n_fail++; $display("FAIL t3_done got=%b exp=0", wr_busy); end
    endtask

    task automatic test_stall();
        m_wvalid = 1'b1; m_wlast = 1'b1; s_wready = '1;
        #1;
        n_cmp++; if (m_wready !== 1'b0 || s_wvalid !== 4'b0) begin
            n_fail++; $display("FAIL t4_early_w got=%b/%b exp=0/0000", m_wready, s_wvalid); end
        m_wvalid = 1'b0; m_wlast = 1'b0; s_wready = '0;
        aw_send(32'h0001_0000, 4'h2, 4'd0);
        for (int i = 0; i < 5; i++) begin
            m_awvalid = 1'b1; m_awaddr = 32'h0002_0000;
            #1;
            n_cmp++; if (s_awvalid !== 4'b0010 || s_awaddr[1] !== 32'h0001_0000 || m_awready !== 1'b0) begin
                n_fail++; $display("FAIL t4_awstall%0d got=%b/%h/%b exp=0010/00010000/0", i, s_awvalid, s_awaddr[1], m_awready); end
            tick();
        end
        m_awvalid = 1'b0; s_awready = '1;
        tick();
        s_awready = '0; m_wvalid = 1'b1; m_wlast = 1'b1; s_wready = '1;
        tick();
        m_wvalid = 1'b0; m_wlast = 1'b0; s_bvalid = 4'b0010; m_bready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++; if (m_bvalid !== 1'b1 || s_bready !== 4'b0 || m_awready !== 1'b0) begin
                n_fail++; $display("FAIL t4_bstall%0d got=%b/%b/%b exp=1/0000/0", i, m_bvalid, s_bready, m_awready); end
            tick();
        end
        // New AW arrives in the same cycle as the B handshake; it lands on the next IDLE cycle.
        m_bready = 1'b1; m_awvalid = 1'b1; m_awaddr = 32'h0002_0000; m_awid = 4'h7;
        #1;
        n_cmp++; if (m_awready !== 1'b0) begin n_fail++; $display("FAIL t4_b2b_hold got=%b exp=0", m_awready); end
        tick();
        m_bready = 1'b0; s_bvalid = '0;
        n_cmp++; if (m_awready !== 1'b1) begin n_fail++; $display("FAIL t4_b2b_idle got=%b exp=1", m_awready); end
        tick();
        m_awvalid = 1'b0; m_awaddr = '0;
    endtask

    task automatic test_async_reset();
        n_cmp++; if (s_awvalid !== 4'b0100) begin n_fail++; $display("FAIL t5_aw got=%b exp=0100", s_awvalid); end
        s_awready = '1;
        tick();
        s_awready = '0; m_wvalid = 1'b1; m_wdata = 32'h55AA_55AA; s_wready = '1;
        #1;
        n_cmp++; if (s_wvalid !== 4'b0100) begin n_fail++; $display("FAIL t5_data got=%b exp=0100", s_wvalid); end
        #1 rst = 1'b0;
        #1;
        n_cmp++; if (wr_busy !== 1'b0 || s_wvalid !== 4'b0 || s_awvalid !== 4'b0 || m_wready !== 1'b0) begin
            n_fail++; $display("FAIL t5_rst got=%b/%b/%b/%b exp=0/0000/0000/0", wr_busy, s_wvalid, s_awvalid, m_wready); end
        n_cmp++; if (s_wdata[2] !== 32'h0 || s_wstrb[2] !== 4'hF || m_bvalid !== 1'b0) begin
            n_fail++; $display("FAIL t5_dflt got=%h/%h/%b exp=0/f/0", s_wdata[2], s_wstrb[2], m_bvalid); end
        idle_inputs();
        tick();
        rst = 1'b1;
        tick();
    endtask

`ifdef WR_BEAT_CHECK_EN
    task automatic test_beat_check();
        n_cmp++; if (wr_err !== 1'b0) begin n_fail++; $display("FAIL t6_err_init got=%b exp=0", wr_err); end
        aw_send(32'h0000_0000, 4'h1, 4'd3);
        s_awready = '1;
        tick();
        s_awready = '0; m_wvalid = 1'b1; m_wlast = 1'b0; s_wready = '1;
        tick();
        m_wlast = 1'b1;
        tick();
        m_wvalid = 1'b0; m_wlast = 1'b0;
        s_bvalid = 4'b0001; s_bresp[0] = 2'b00; s_bid[0] = 8'h01; m_bready = 1'b1;
        #1;
        n_cmp++; if (wr_err !== 1'b1 || m_bresp !== 2'b10) begin
            n_fail++; $display("FAIL t6_slverr got=%b/%b exp=1/10", wr_err, m_bresp); end
        tick();
        idle_inputs();
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_unmapped();
        test_stall();
        test_async_reset();
`ifdef WR_BEAT_CHECK_EN
        test_beat_check();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
